// File: rtl/hyperram_ctrl_if.sv
// Host request/data and hyperbus_interface command/data signals seen by hyperram_ctrl.
// slave = controller view, master = surrounding host + interface view.
interface hyperram_ctrl_if #(
   parameter int unsigned W_ADDR     = 22,
   parameter int unsigned W_BURSTLEN = 5
);
   logic [1:0]            capture_shmoo;
   logic                  init_done;
   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_write;
   logic [W_ADDR-1:0]     req_addr;
   logic [W_BURSTLEN-1:0] req_len;
   logic [7:0]            host_wdata;
   logic                  host_wdata_rdy;
   logic [7:0]            host_rdata;
   logic                  host_rdata_vld;
   logic [47:0]           if_cmd_addr;
   logic                  if_start_reg;
   logic                  if_start_data;
   logic                  if_start_rdy;
   logic [W_BURSTLEN-1:0] if_burst_len;
   logic [3:0]            if_latency;
   logic [3:0]            if_recovery;
   logic [1:0]            if_capture_shmoo;
   logic [7:0]            if_wdata;
   logic                  if_wdata_rdy;
   logic [7:0]            if_rdata;
   logic                  if_rdata_vld;

   modport slave (
      input  capture_shmoo, req_vld, req_write, req_addr, req_len, host_wdata,
             if_start_rdy, if_wdata_rdy, if_rdata, if_rdata_vld,
      output init_done, req_rdy, host_wdata_rdy, host_rdata, host_rdata_vld,
             if_cmd_addr, if_start_reg, if_start_data, if_burst_len, if_latency,
             if_recovery, if_capture_shmoo, if_wdata
   );

   modport master (
      output capture_shmoo, req_vld, req_write, req_addr, req_len, host_wdata,
             if_start_rdy, if_wdata_rdy, if_rdata, if_rdata_vld,
      input  init_done, req_rdy, host_wdata_rdy, host_rdata, host_rdata_vld,
             if_cmd_addr, if_start_reg, if_start_data, if_burst_len, if_latency,
             if_recovery, if_capture_shmoo, if_wdata
   );
endinterface

// File: rtl/hyperram_ctrl.sv
// HyperRAM sequencer: power-up wait, CR0 write, then one host burst at a time
// driven through the hyperbus_interface command port.
module hyperram_ctrl #(
   parameter int unsigned W_ADDR         = 22,
   parameter int unsigned W_BURSTLEN     = 5,
   parameter int unsigned POWERUP_CYCLES = 15000,
   parameter logic [15:0] CFG_CR0        = 16'h8f1f,
   parameter int unsigned LATENCY        = 6,
   parameter int unsigned RECOVERY       = 2
) (
   input  logic           clk,
   input  logic           rst,
   hyperram_ctrl_if.slave bus
);
   localparam int unsigned W_CNT = $clog2(POWERUP_CYCLES + 1);
   localparam logic [47:0] CR0_WRITE_CA = 48'h6000_0100_0000;

   typedef enum logic [2:0] {PWR_WAIT, CFG_ISSUE, CFG_BUSY, IDLE, ISSUE, BUSY} state_t;

   state_t                state_q, state_d;
   logic [W_CNT-1:0]      cnt_q, cnt_d;
   logic [47:0]           cmd_q, cmd_d;
   logic [W_BURSTLEN-1:0] len_q, len_d;
   logic                  write_q, write_d;
   logic                  lo_byte_q, lo_byte_d;
   logic                  init_done_q, init_done_d;

   logic                  req_rdy;
   logic                  req_hs;
   logic [47:0]           req_ca;
   logic                  start_reg;
   logic                  start_data;
   logic [7:0]            wdata;
   logic                  host_wdata_rdy;

   // CA packet: R/W, memory space, linear burst, row/upper column, lower column
   always_comb begin
      req_ca         = '0;
      req_ca[47]     = ~bus.req_write;
      req_ca[45]     = 1'b1;
      req_ca[44:16]  = 29'(bus.req_addr >> 3);
      req_ca[2:0]    = bus.req_addr[2:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PWR_WAIT;
         cnt_q       <= '0;
         cmd_q       <= '0;
         len_q       <= '0;
         write_q     <= 1'b0;
         lo_byte_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         write_q     <= write_d;
         lo_byte_q   <= lo_byte_d;
         init_done_q <= init_done_d;
      end
   end

   assign req_hs = bus.req_vld & req_rdy;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      write_d     = write_q;
      lo_byte_d   = lo_byte_q;
      init_done_d = init_done_q;
      case (state_q)
         PWR_WAIT: begin
            cnt_d = cnt_q + W_CNT'(1);
            if (cnt_q == W_CNT'(POWERUP_CYCLES - 1)) begin
               state_d = CFG_ISSUE;
               cmd_d   = CR0_WRITE_CA;
               len_d   = W_BURSTLEN'(1);
               write_d = 1'b1;
            end
         end
         CFG_ISSUE: begin
            lo_byte_d = 1'b0;
            if (bus.if_start_rdy) state_d = CFG_BUSY;
         end
         CFG_BUSY: begin
            if (bus.if_wdata_rdy) lo_byte_d = 1'b1;
            if (bus.if_start_rdy) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE: begin
            // zero-length requests are acknowledged without touching the bus
            if (req_hs) begin
               cmd_d   = req_ca;
               len_d   = bus.req_len;
               write_d = bus.req_write;
               if (bus.req_len != '0) state_d = ISSUE;
            end
         end
         ISSUE:   state_d = BUSY;
         BUSY:    if (bus.if_start_rdy) state_d = IDLE;
         default: state_d = PWR_WAIT;
      endcase
   end

   always_comb begin
      req_rdy        = (state_q == IDLE) & bus.if_start_rdy;
      start_reg      = (state_q == CFG_ISSUE) & bus.if_start_rdy;
      start_data     = (state_q == ISSUE);
      host_wdata_rdy = (state_q == BUSY) & write_q & bus.if_wdata_rdy;
      wdata          = bus.host_wdata;
      if (state_q == CFG_BUSY) wdata = lo_byte_q ? CFG_CR0[7:0] : CFG_CR0[15:8];
   end

   assign bus.init_done        = init_done_q;
   assign bus.req_rdy          = req_rdy;
   assign bus.host_wdata_rdy   = host_wdata_rdy;
   assign bus.host_rdata       = bus.if_rdata;
   assign bus.host_rdata_vld   = bus.if_rdata_vld;
   assign bus.if_cmd_addr      = cmd_q;
   assign bus.if_start_reg     = start_reg;
   assign bus.if_start_data    = start_data;
   assign bus.if_burst_len     = len_q;
   assign bus.if_latency       = 4'(LATENCY);
   assign bus.if_recovery      = 4'(RECOVERY);
   assign bus.if_capture_shmoo = bus.capture_shmoo;
   assign bus.if_wdata         = wdata;
endmodule

// File: tb/tb_hyperram_ctrl.sv
// Scoreboard bench for hyperram_ctrl: a behavioural hyperbus_interface stand-in,
// a host driver, and a negedge monitor that pops expected commands and bytes.
module tb_hyperram_ctrl;
   localparam int unsigned W_ADDR = 22;
   localparam int unsigned W_BL   = 5;
   localparam int unsigned PWR    = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   hyperram_ctrl_if #(.W_ADDR(W_ADDR), .W_BURSTLEN(W_BL)) bus ();

   hyperram_ctrl #(
      .W_ADDR(W_ADDR), .W_BURSTLEN(W_BL), .POWERUP_CYCLES(PWR),
      .CFG_CR0(16'h8f1f), .LATENCY(6), .RECOVERY(2)
   ) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            is_reg;
      logic [47:0]     ca;
      logic [W_BL-1:0] len;
   } cmd_t;

   int n_chk  = 0;
   int n_fail = 0;

   cmd_t       exp_cmd[$];
   logic [7:0] exp_wbyte[$];
   logic [7:0] exp_rbyte[$];
   logic [7:0] host_src[$];

   bit start_seen, start_wr, start_isdata;
   int start_bytes;
   bit phy_busy, phy_wr, phy_isdata;
   int phy_delay, phy_left;
   bit take;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference CA packet from the bit-field definition, using plain arithmetic.
   function automatic logic [47:0] ca_model(bit wr, logic [W_ADDR-1:0] addr);
      logic [47:0] r;
      r = 48'(addr % 8) + (48'(addr / 8) << 16) + (48'd1 << 45);
      if (!wr) r = r + (48'd1 << 47);
      return r;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.if_start_reg || bus.if_start_data) begin
            if (exp_cmd.size() == 0) begin
               check("unexpected_start", {bus.if_start_reg, bus.if_start_data}, 0);
            end else begin
               cmd_t c;
               c = exp_cmd.pop_front();
               check("start_kind", {bus.if_start_reg, bus.if_start_data},
                     c.is_reg ? 2'b10 : 2'b01);
               check("if_cmd_addr", bus.if_cmd_addr, c.ca);
               check("if_burst_len", bus.if_burst_len, c.len);
            end
            start_seen   = 1'b1;
            start_wr     = !bus.if_cmd_addr[47];
            start_isdata = bus.if_start_data;
            start_bytes  = 2 * int'(bus.if_burst_len);
         end
         if (bus.if_wdata_rdy) begin
            check("host_wdata_rdy", bus.host_wdata_rdy, phy_isdata);
            if (exp_wbyte.size() == 0) check("extra_wbyte", bus.if_wdata, 'x);
            else check("if_wdata", bus.if_wdata, exp_wbyte.pop_front());
         end
         if (bus.if_rdata_vld) begin
            check("host_rdata_vld", bus.host_rdata_vld, 1);
            if (exp_rbyte.size() == 0) check("extra_rbyte", bus.host_rdata, 'x);
            else check("host_rdata", bus.host_rdata, exp_rbyte.pop_front());
         end
      end
   end

   // hyperbus_interface stand-in: drops start_rdy after a start, random data gaps
   always @(posedge clk) begin
      #1;
      if (rst) begin
         bus.if_start_rdy = 1'b1;
         bus.if_wdata_rdy = 1'b0;
         bus.if_rdata_vld = 1'b0;
         phy_busy   = 1'b0;
         phy_isdata = 1'b0;
         start_seen = 1'b0;
      end else if (start_seen) begin
         start_seen       = 1'b0;
         phy_busy         = 1'b1;
         bus.if_start_rdy = 1'b0;
         phy_wr           = start_wr;
         phy_isdata       = start_isdata;
         phy_left         = start_bytes;
         phy_delay        = $urandom_range(0, 3);
      end else if (phy_busy) begin
         bus.if_wdata_rdy = 1'b0;
         bus.if_rdata_vld = 1'b0;
         if (phy_delay > 0) begin
            phy_delay--;
         end else if (phy_left > 0) begin
            if ($urandom_range(0, 3) != 0) begin
               phy_left--;
               if (phy_wr) begin
                  bus.if_wdata_rdy = 1'b1;
               end else begin
                  bus.if_rdata     = 8'($urandom);
                  bus.if_rdata_vld = 1'b1;
                  exp_rbyte.push_back(bus.if_rdata);
               end
            end
         end else begin
            phy_busy         = 1'b0;
            phy_isdata       = 1'b0;
            bus.if_start_rdy = 1'b1;
         end
      end
   end

   // Host write-data source: advance after each consumed byte
   always @(negedge clk) take = bus.host_wdata_rdy;
   always @(posedge clk) begin
      #1;
      if (take && host_src.size() > 0) void'(host_src.pop_front());
      bus.host_wdata = (host_src.size() > 0) ? host_src[0] : 8'h00;
   end

   task automatic check_reset_outputs();
      check("rst_init_done", bus.init_done, 0);
      check("rst_req_rdy", bus.req_rdy, 0);
      check("rst_start_reg", bus.if_start_reg, 0);
      check("rst_start_data", bus.if_start_data, 0);
      check("rst_cmd_addr", bus.if_cmd_addr, 0);
      check("rst_burst_len", bus.if_burst_len, 0);
      check("rst_host_wdata_rdy", bus.host_wdata_rdy, 0);
      check("rst_host_rdata_vld", bus.host_rdata_vld, 0);
   endtask

   task automatic run_init();
      int k;
      exp_cmd.push_back('{1'b1, 48'h6000_0100_0000, 5'd1});
      exp_wbyte.push_back(8'h8f);
      exp_wbyte.push_back(8'h1f);
      @(negedge clk);
      #1 rst = 1'b0;
      k = 0;
      for (int i = 0; i < int'(PWR) + 20; i++) begin
         @(negedge clk);
         k++;
         if (bus.if_start_reg) break;
      end
      check("powerup_cycles", k, PWR);
      check("init_done_at_start", bus.init_done, 0);
      @(negedge clk);
      check("init_done_while_busy", bus.init_done, 0);
      for (int i = 0; i < 200; i++) begin
         if (bus.init_done) break;
         @(negedge clk);
      end
      check("init_done", bus.init_done, 1);
      check("init_bytes_left", exp_wbyte.size(), 0);
   endtask

   task automatic issue_req(bit wr, logic [W_ADDR-1:0] addr, logic [W_BL-1:0] len);
      bit ok;
      if (len != 0) exp_cmd.push_back('{1'b0, ca_model(wr, addr), len});
      if (wr) begin
         for (int i = 0; i < 2 * int'(len); i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_wbyte.push_back(b);
            host_src.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      bus.req_vld   = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_len   = len;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.req_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      check("req_handshake", ok, 1);
      @(posedge clk);
      #1;
      bus.req_vld  = 1'b0;
      bus.req_addr = W_ADDR'($urandom);
      bus.req_len  = W_BL'($urandom);
      @(negedge clk);
      check("req_rdy_after_hs", bus.req_rdy, (len == 0));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         if (bus.req_rdy) break;
         @(negedge clk);
      end
      check("burst_done", bus.req_rdy, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.capture_shmoo = 2'b10;
      bus.req_vld       = 1'b0;
      bus.req_write     = 1'b0;
      bus.req_addr      = '0;
      bus.req_len       = '0;
      bus.host_wdata    = 8'h00;
      bus.if_start_rdy  = 1'b1;
      bus.if_wdata_rdy  = 1'b0;
      bus.if_rdata      = 8'h00;
      bus.if_rdata_vld  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();

      run_init();
      check("if_latency", bus.if_latency, 6);
      check("if_recovery", bus.if_recovery, 2);
      check("if_capture_shmoo", bus.if_capture_shmoo, 2'b10);

      issue_req(1'b0, 22'h12345, 5'd4);
      wait_idle();
      check("read_bytes_left", exp_rbyte.size(), 0);
      issue_req(1'b1, 22'h0, 5'd2);
      wait_idle();
      check("write_bytes_left", exp_wbyte.size(), 0);
      issue_req(1'b0, 22'h3abcd, 5'd0);

      for (int n = 0; n < 30; n++) begin
         bit              wr;
         logic [W_BL-1:0] len;
         wr  = 1'($urandom_range(0, 1));
         len = W_BL'($urandom_range(0, 8));
         issue_req(wr, W_ADDR'($urandom), len);
         if (len != 0) wait_idle();
      end

      // Reset in the middle of a write burst
      issue_req(1'b1, W_ADDR'($urandom), 5'd8);
      for (int i = 0; i < 300; i++) begin
         if (exp_wbyte.size() <= 12) break;
         @(negedge clk);
      end
      check("midwrite_progress", exp_wbyte.size() <= 12, 1);
      #1 rst = 1'b1;
      exp_cmd.delete();
      exp_wbyte.delete();
      exp_rbyte.delete();
      host_src.delete();
      @(negedge clk);
      check_reset_outputs();
      run_init();

      issue_req(1'b0, W_ADDR'($urandom), 5'd3);
      wait_idle();

      repeat (4) @(negedge clk);
      check("cmd_queue_empty", exp_cmd.size(), 0);
      check("wbyte_queue_empty", exp_wbyte.size(), 0);
      check("rbyte_queue_empty", exp_rbyte.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hyperram_ctrl.md
Name: hyperram_ctrl

Overview:
- Sequencer in front of hyperbus_interface; owns the interface's command port.
- After reset it waits out the HyperRAM power-up time, then writes Configuration Register 0.
- It then accepts host burst requests one at a time, builds the 48-bit CA packet and pulses the interface start.
- Host data streams pass through, except during the init register write, where the controller sources write data itself.

Parameters:
- W_ADDR, 22, host halfword address width (22 = 8 MiB device)
- W_BURSTLEN, 5, burst length field width in halfwords; matches hyperbus_interface
- POWERUP_CYCLES, 15000, clk cycles from reset release to the CR0 write (150 us at 100 MHz); must be >= 1
- CFG_CR0, 16'h8f1f, value written to CR0 during init
- LATENCY, 6, drives if_latency; must match the CR0 latency field
- RECOVERY, 2, drives if_recovery

Ports:
- clk  in  1  system clock, the only clock
- rst  in  1  synchronous, active-high reset
- capture_shmoo  in  2  passed to if_capture_shmoo; static
- init_done  out  1  high once the CR0 write has completed
- req_vld  in  1  host request valid
- req_rdy  out  1  controller accepts a request
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  W_ADDR  halfword start address
- req_len  in  W_BURSTLEN  halfword count
- host_wdata  in  8  write byte stream
- host_wdata_rdy  out  1  byte consumed this cycle
- host_rdata  out  8  read byte stream
- host_rdata_vld  out  1  read byte valid
- if_cmd_addr  out  48  CA packet
- if_start_reg  out  1  register access start pulse
- if_start_data  out  1  array access start pulse
- if_start_rdy  in  1  interface idle
- if_burst_len  out  W_BURSTLEN  halfword count
- if_latency  out  4  LATENCY
- if_recovery  out  4  RECOVERY
- if_capture_shmoo  out  2  = capture_shmoo
- if_wdata  out  8  write byte to the interface
- if_wdata_rdy  in  1  interface consumed the byte
- if_rdata  in  8  read byte
- if_rdata_vld  in  1  read byte valid

Behaviour:
- States: PWR_WAIT, CFG_ISSUE, CFG_BUSY, IDLE, ISSUE, BUSY.
- Reset state: PWR_WAIT, counter = 0. init_done=0, req_rdy=0, start pulses=0, if_cmd_addr=0, if_burst_len=0, host_wdata_rdy=0, host_rdata_vld=0.
- Reset mid-burst: abandon the burst immediately and re-run the full init sequence. The RAM is not reset.
- PWR_WAIT: count clk cycles; after POWERUP_CYCLES cycles go to CFG_ISSUE.
- CFG_ISSUE:
  - Load if_cmd_addr = 48'h6000_0100_0000 (register write to CR0) and if_burst_len = 1.
  - When if_start_rdy=1, pulse if_start_reg for exactly one cycle, then go to CFG_BUSY.
- CFG_BUSY:
  - if_wdata = CFG_CR0[15:8] until the first if_wdata_rdy, then CFG_CR0[7:0].
  - host_wdata_rdy stays 0.
  - When if_start_rdy=1, go to IDLE and set init_done=1. init_done stays 1 until reset.
- Interface timing contract: if_start_rdy is low in the cycle after a start pulse is sampled. The *BUSY states therefore exit on the first cycle in which if_start_rdy=1.
- IDLE: req_rdy = if_start_rdy. A handshake (req_vld & req_rdy) latches req_*.
  - If req_len = 0: complete with no bus transaction and stay in IDLE.
  - Otherwise: go to ISSUE.
- ISSUE: pulse if_start_data for one cycle, then go to BUSY. req_rdy=0 in ISSUE and BUSY.
- CA packet bit map:
  - [47] = !req_write.
  - [46] = 0 (memory space).
  - [45] = 1 (linear burst).
  - [44:16] = zero-extended addr[W_ADDR-1:3].
  - [15:3] = 0.
  - [2:0] = addr[2:0].
- Command hold: if_cmd_addr and if_burst_len are held stable from the start pulse until return to IDLE.
- BUSY, write: if_wdata = host_wdata; host_wdata_rdy = if_wdata_rdy (combinational). Byte order within each halfword is [15:8] first. The host must supply 2*req_len bytes.
- Read path, all states: host_rdata = if_rdata; host_rdata_vld = if_rdata_vld (combinational, zero latency).
- No burst splitting or address wrap handling: the host must not cross the end of the device.

Test Plan:
- Reset release, POWERUP_CYCLES=10 -> first if_start_reg pulse exactly 10 cycles later, with if_cmd_addr=48'h6000_0100_0000 and if_burst_len=1; init_done=0 until if_start_rdy returns.
- Init write data -> bytes 8'h8f then 8'h1f on successive if_wdata_rdy; host_wdata_rdy stays 0; init_done=1 after completion.
- Read burst, addr=22'h12345, len=4 -> one if_start_data pulse with if_cmd_addr=48'hA000_2468_0005 and if_burst_len=4; 8 if_rdata bytes forwarded unchanged to host_rdata.
- Write burst, addr=0, len=2 -> if_cmd_addr=48'h2000_0000_0000; 4 host bytes consumed, one per if_wdata_rdy; req_rdy=0 until if_start_rdy=1.
- req_len=0 while idle -> handshake completes, no start pulse, req_rdy remains 1.
- rst asserted mid-write -> next cycle all outputs at reset values, init_done=0, and the init sequence repeats in full.
